// File: rtl/radar_gate_gen.sv
// radar_gate_gen
//   Receive range-gate generator. Each accepted trigger (external PRF sync
//   edge or internal period counter) starts a programmable delay followed by
//   a gate of programmable width. gate_enable drives the decimation strobe
//   enable so that samples are only taken inside the range window.
//
// Ports
//   master_clk     system clock, rising edge
//   reset_n        asynchronous active-low reset
//   serial_addr    setting bus address
//   serial_data    setting bus data
//   serial_strobe  setting bus write strobe (one cycle)
//   sync_in        external PRF trigger, asynchronous to master_clk
//   gate_enable    sampling window (registered)
//   trig_out       one-cycle pulse per accepted trigger
//   busy           high while a delay/gate window is in progress
//   overrun_count  triggers rejected while busy, saturating
//
// FSM states
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_IDLE  | waiting for a trigger
//   ST_DELAY | counting down the delay before the gate opens
//   ST_GATE  | gate open, counting down the gate width
module radar_gate_gen #(
  parameter logic [6:0] ADDR_DELAY  = 7'd80,
  parameter logic [6:0] ADDR_WIDTH  = 7'd81,
  parameter logic [6:0] ADDR_PERIOD = 7'd82,
  parameter logic [6:0] ADDR_CTRL   = 7'd83
) (
  input  logic        master_clk,
  input  logic        reset_n,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic        sync_in,
  output logic        gate_enable,
  output logic        trig_out,
  output logic        busy,
  output logic [15:0] overrun_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_GATE  = 2'd2;

  logic [15:0] delay_reg;
  logic [15:0] width_reg;
  logic [23:0] period_reg;
  logic        run_reg;
  logic        int_sync_reg;

  logic        wr_delay;
  logic        wr_width;
  logic        wr_period;
  logic        wr_ctrl;
  logic        abort;
  logic        clr_ovr;

  logic        sync_ff1;
  logic        sync_ff2;
  logic        sync_ff3;
  logic        ext_trig;

  logic [23:0] int_cnt;
  logic        int_active;
  logic        int_trig;

  logic        trig;
  logic        accept;
  logic        reject;

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [15:0] shadow_width;

  logic        unused_data;
  assign unused_data = ^serial_data[31:24];

  assign wr_delay  = serial_strobe && (serial_addr == ADDR_DELAY);
  assign wr_width  = serial_strobe && (serial_addr == ADDR_WIDTH);
  assign wr_period = serial_strobe && (serial_addr == ADDR_PERIOD);
  assign wr_ctrl   = serial_strobe && (serial_addr == ADDR_CTRL);

  // Writing run=0 kills any window on the same edge the register clears.
  assign abort   = wr_ctrl && !serial_data[0];
  assign clr_ovr = wr_ctrl && serial_data[2];

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      delay_reg    <= 16'd0;
      width_reg    <= 16'd0;
      period_reg   <= 24'd0;
      run_reg      <= 1'b0;
      int_sync_reg <= 1'b0;
    end else begin
      if (wr_delay)  delay_reg  <= serial_data[15:0];
      if (wr_width)  width_reg  <= serial_data[15:0];
      if (wr_period) period_reg <= serial_data[23:0];
      if (wr_ctrl) begin
        run_reg      <= serial_data[0];
        int_sync_reg <= serial_data[1];
      end
    end
  end

  // Two-flop synchronizer, a history flop, then a registered rising-edge
  // detect so ext_trig comes straight from a flop.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
      sync_ff3 <= 1'b0;
      ext_trig <= 1'b0;
    end else begin
      sync_ff1 <= sync_in;
      sync_ff2 <= sync_ff1;
      sync_ff3 <= sync_ff2;
      ext_trig <= sync_ff2 && !sync_ff3;
    end
  end

  assign int_active = run_reg && int_sync_reg;
  assign int_trig   = int_active && (period_reg != 24'd0) &&
                      (int_cnt == period_reg - 24'd1);

  // The >= wrap keeps the counter bounded if period is shrunk mid-count.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      int_cnt <= 24'd0;
    end else if (!int_active || (period_reg == 24'd0) ||
                 (int_cnt >= period_reg - 24'd1)) begin
      int_cnt <= 24'd0;
    end else begin
      int_cnt <= int_cnt + 24'd1;
    end
  end

  assign trig   = run_reg && (int_sync_reg ? int_trig : ext_trig);
  assign accept = trig && (state == ST_IDLE) && !abort;
  assign reject = trig && (state != ST_IDLE);

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= 16'd0;
      shadow_width <= 16'd0;
    end else if (abort) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shadow_width <= width_reg;
            if (delay_reg != 16'd0) begin
              state <= ST_DELAY;
              cnt   <= delay_reg - 16'd1;
            end else if (width_reg != 16'd0) begin
              state <= ST_GATE;
              cnt   <= width_reg - 16'd1;
            end
          end
        end
        ST_DELAY: begin
          if (cnt == 16'd0) begin
            if (shadow_width != 16'd0) begin
              state <= ST_GATE;
              cnt   <= shadow_width - 16'd1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_GATE: begin
          if (cnt == 16'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

  // Outputs lag the state by one cycle so the window starts the cycle after
  // trig_out; abort forces them low on the same edge the state resets.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_out      <= 1'b0;
      gate_enable   <= 1'b0;
      busy          <= 1'b0;
      overrun_count <= 16'd0;
    end else begin
      trig_out    <= accept;
      gate_enable <= !abort && (state == ST_GATE);
      busy        <= !abort && (state != ST_IDLE);
      if (clr_ovr) begin
        overrun_count <= 16'd0;
      end else if (reject && (overrun_count != 16'hFFFF)) begin
        overrun_count <= overrun_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_radar_gate_gen.sv
module tb_radar_gate_gen;

  localparam logic [6:0] A_DELAY  = 7'd80;
  localparam logic [6:0] A_WIDTH  = 7'd81;
  localparam logic [6:0] A_PERIOD = 7'd82;
  localparam logic [6:0] A_CTRL   = 7'd83;

  logic        clk;
  logic        rst_n;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        sync_in;
  logic        gate_enable;
  logic        trig_out;
  logic        busy;
  logic [15:0] overrun_count;

  int checks;
  int failures;

  radar_gate_gen dut (
    .master_clk    (clk),
    .reset_n       (rst_n),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .sync_in       (sync_in),
    .gate_enable   (gate_enable),
    .trig_out      (trig_out),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed window: optional delay/width writes, a ctrl write, a sync
  // pulse, then an optional setting-bus write at cycle wr_at of the window.
  typedef struct {
    bit          wr_dw;
    int          dly;
    int          wid;
    int          ctrl;
    int          wr_at;
    logic [6:0]  wr_addr;
    int          wr_data;
    int          e_trigs;
    int          e_tidx;
    int          e_goff;
    int          e_glen;
    int          e_blen;
  } vec_t;

  function automatic vec_t mkv(input bit wr_dw, input int dly, input int wid,
                               input int ctrl, input int wr_at,
                               input logic [6:0] wr_addr, input int wr_data,
                               input int e_trigs, input int e_tidx,
                               input int e_goff, input int e_glen,
                               input int e_blen);
    vec_t v;
    v.wr_dw = wr_dw; v.dly = dly; v.wid = wid; v.ctrl = ctrl;
    v.wr_at = wr_at; v.wr_addr = wr_addr; v.wr_data = wr_data;
    v.e_trigs = e_trigs; v.e_tidx = e_tidx; v.e_goff = e_goff;
    v.e_glen = e_glen; v.e_blen = e_blen;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    tick();
    serial_strobe = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int trigs, tidx, gfirst, glen, blen, goff;
    if (v.wr_dw) begin
      wr(A_DELAY, v.dly);
      wr(A_WIDTH, v.wid);
    end
    wr(A_CTRL, v.ctrl);
    trigs = 0; tidx = -1; gfirst = -1; glen = 0; blen = 0;
    for (int i = 0; i < 60; i++) begin
      sync_in       = (i < 2);
      serial_strobe = (i == v.wr_at);
      serial_addr   = v.wr_addr;
      serial_data   = v.wr_data;
      tick();
      if (trig_out) begin
        trigs++;
        if (tidx < 0) tidx = i + 1;
      end
      if (gate_enable) begin
        glen++;
        if (gfirst < 0) gfirst = i + 1;
      end
      if (busy) blen++;
    end
    serial_strobe = 1'b0;
    sync_in = 1'b0;
    goff = (gfirst < 0 || tidx < 0) ? -1 : gfirst - tidx;
    chk({tag, "_trigs"},    trigs, v.e_trigs);
    chk({tag, "_trig_idx"}, tidx,  v.e_tidx);
    chk({tag, "_gate_off"}, goff,  v.e_goff);
    chk({tag, "_gate_len"}, glen,  v.e_glen);
    chk({tag, "_busy_len"}, blen,  v.e_blen);
  endtask

  vec_t vecs[9];
  int   exp_ovr[5];
  int   exp_trg[5];

  initial begin
    int trigs, glen, tfirst;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    serial_addr = 7'd0;
    serial_data = 32'd0;
    serial_strobe = 1'b0;
    sync_in = 1'b0;

    // trig_idx is counted from the cycle sync_in rises (edge captured at
    // index 1, so index 4 is three cycles after the edge).
    vecs[0] = mkv(1, 10, 5, 1, -1, 7'd0,    0, 1, 4, 11,  5, 15);
    vecs[1] = mkv(1,  0, 4, 1, -1, 7'd0,    0, 1, 4,  1,  4,  4);
    vecs[2] = mkv(1,  0, 0, 1, -1, 7'd0,    0, 1, 4, -1,  0,  0);
    vecs[3] = mkv(1,  3, 1, 1, -1, 7'd0,    0, 1, 4,  4,  1,  4);
    vecs[4] = mkv(1,  1, 7, 1, -1, 7'd0,    0, 1, 4,  2,  7,  8);
    vecs[5] = mkv(1,  2, 5, 1,  8, A_WIDTH, 20, 1, 4,  3,  5,  7);
    vecs[6] = mkv(0,  0, 0, 1, -1, 7'd0,    0, 1, 4,  3, 20, 22);
    vecs[7] = mkv(1, 10, 5, 1,  6, A_CTRL,  0, 1, 4, -1,  0,  2);
    vecs[8] = mkv(0,  0, 0, 0, -1, 7'd0,    0, 0, -1, -1, 0,  0);

    #1;
    chk("rst_gate",    gate_enable,   0);
    chk("rst_trig",    trig_out,      0);
    chk("rst_busy",    busy,          0);
    chk("rst_ovr",     overrun_count, 0);
    #22 rst_n = 1'b1;
    tick();

    for (int k = 0; k < 9; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Internal PRF: period 100, delay 20, width 30, with sync_in toggling.
    wr(A_PERIOD, 100);
    wr(A_DELAY, 20);
    wr(A_WIDTH, 30);
    wr(A_CTRL, 3);
    trigs = 0; glen = 0; tfirst = -1;
    for (int i = 0; i < 360; i++) begin
      if (trig_out) begin
        trigs++;
        if (tfirst < 0) tfirst = i;
      end
      if (gate_enable) glen++;
      sync_in = ((i / 7) % 2) == 1;
      tick();
    end
    chk("int_first_trig", tfirst, 100);
    chk("int_trig_count", trigs, 3);
    chk("int_gate_cycles", glen, 90);
    chk("int_overrun", overrun_count, 0);
    sync_in = 1'b0;
    wr(A_CTRL, 0);
    repeat (10) tick();

    // Overrun: delay 50, width 50, external edges every 40 cycles.
    exp_ovr[0] = 0; exp_ovr[1] = 1; exp_ovr[2] = 2; exp_ovr[3] = 2; exp_ovr[4] = 3;
    exp_trg[0] = 1; exp_trg[1] = 1; exp_trg[2] = 1; exp_trg[3] = 2; exp_trg[4] = 2;
    wr(A_DELAY, 50);
    wr(A_WIDTH, 50);
    wr(A_CTRL, 1);
    trigs = 0;
    for (int n = 0; n < 5; n++) begin
      sync_in = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (i == 2) sync_in = 1'b0;
        tick();
        if (trig_out) trigs++;
      end
      chk($sformatf("ovr_count_%0d", n), overrun_count, exp_ovr[n]);
      chk($sformatf("ovr_trigs_%0d", n), trigs, exp_trg[n]);
    end
    sync_in = 1'b1;
    tick();
    tick();
    sync_in = 1'b0;
    tick();
    wr(A_CTRL, 5);
    chk("ovr_clr_wins", overrun_count, 0);
    chk("ovr_clr_busy", busy, 1);
    repeat (60) tick();
    chk("ovr_idle_after", busy, 0);

    // Reset asserted mid-gate with a nonzero overrun count.
    wr(A_DELAY, 5);
    wr(A_WIDTH, 10);
    wr(A_CTRL, 1);
    sync_in = 1'b1;
    for (int i = 0; i < 40 && !gate_enable; i++) begin
      if (i == 2) sync_in = 1'b0;
      tick();
    end
    sync_in = 1'b0;
    chk("rst_seq_gate_seen", gate_enable, 1);
    sync_in = 1'b1;
    tick();
    tick();
    sync_in = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_seq_ovr_pre", overrun_count, 1);
    chk("rst_seq_gate_pre", gate_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_gate", gate_enable, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ovr", overrun_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // Delay and width must be back to 0: trigger fires, no window.
    run_vec(mkv(0, 0, 0, 1, -1, 7'd0, 0, 1, 4, -1, 0, 0), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
